// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage core: shadow scoreboard, stall/squash/freeze control,
// EX operand-forwarding selects and saturating debug counters.
module hazard_controller #(
  parameter int CNT_W    = 16,
  parameter int XLEN_IDX = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                de_valid,
  input  logic [XLEN_IDX-1:0] de_rs1,
  input  logic [XLEN_IDX-1:0] de_rs2,
  input  logic                de_rs1_used,
  input  logic                de_rs2_used,
  input  logic [XLEN_IDX-1:0] de_rd,
  input  logic                de_reg_write,
  input  logic                de_mem_read,
  input  logic                br_taken,
  input  logic                mem_busy,
  output logic                pc_write,
  output logic                de_ld,
  output logic                de_flush,
  output logic                ex_ld,
  output logic                ex_flush,
  output logic [1:0]          rs1_sel,
  output logic [1:0]          rs2_sel,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt,
  output logic [CNT_W-1:0]    busy_cnt
);

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FREEZE,
    ACT_SQUASH,
    ACT_STALL,
    ACT_NORMAL
  } action_e;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  // Shadow scoreboard: what currently sits in the EX and MEM pipeline registers.
  logic                ex_valid;
  logic [XLEN_IDX-1:0] ex_rd;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                mem_valid;
  logic [XLEN_IDX-1:0] mem_rd;
  logic                mem_reg_write;

  logic                ex_hit1;
  logic                ex_hit2;
  logic                mem_hit1;
  logic                mem_hit2;
  logic                load_use;
  logic                advance;
  action_e             action;
  logic [1:0]          rs1_sel_next;
  logic [1:0]          rs2_sel_next;

  function automatic logic slot_hit(
    input logic                valid,
    input logic                reg_write,
    input logic [XLEN_IDX-1:0] rd,
    input logic [XLEN_IDX-1:0] rs,
    input logic                used
  );
    return valid && reg_write && used && (rd == rs) && (rs != '0);
  endfunction

  assign ex_hit1  = slot_hit(ex_valid,  ex_reg_write,  ex_rd,  de_rs1, de_rs1_used);
  assign ex_hit2  = slot_hit(ex_valid,  ex_reg_write,  ex_rd,  de_rs2, de_rs2_used);
  assign mem_hit1 = slot_hit(mem_valid, mem_reg_write, mem_rd, de_rs1, de_rs1_used);
  assign mem_hit2 = slot_hit(mem_valid, mem_reg_write, mem_rd, de_rs2, de_rs2_used);

  assign load_use = de_valid && ex_mem_read && (ex_hit1 || ex_hit2);

  always_comb begin
    action = ACT_NORMAL;
    if (reset)         action = ACT_RESET;
    else if (mem_busy) action = ACT_FREEZE;
    else if (br_taken) action = ACT_SQUASH;
    else if (load_use) action = ACT_STALL;
  end

  always_comb begin
    pc_write = 1'b0;
    de_ld    = 1'b0;
    de_flush = 1'b0;
    ex_ld    = 1'b0;
    ex_flush = 1'b0;
    case (action)
      ACT_RESET: begin
        de_flush = 1'b1;
        ex_flush = 1'b1;
      end
      ACT_FREEZE: begin
      end
      ACT_SQUASH: begin
        pc_write = 1'b1;
        de_ld    = 1'b1;
        de_flush = 1'b1;
        ex_ld    = 1'b1;
        ex_flush = 1'b1;
      end
      ACT_STALL: begin
        ex_ld    = 1'b1;
        ex_flush = 1'b1;
      end
      default: begin
        pc_write = 1'b1;
        de_ld    = 1'b1;
        ex_ld    = 1'b1;
      end
    endcase
  end

  // Only a normal cycle moves the DE instruction into EX; squash and stall insert a bubble.
  assign advance = (action == ACT_NORMAL);

  always_comb begin
    rs1_sel_next = SEL_RF;
    rs2_sel_next = SEL_RF;
    if (advance && de_valid) begin
      if (ex_hit1)       rs1_sel_next = SEL_MEM;
      else if (mem_hit1) rs1_sel_next = SEL_WB;
      if (ex_hit2)       rs2_sel_next = SEL_MEM;
      else if (mem_hit2) rs2_sel_next = SEL_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_valid     <= 1'b0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      rs1_sel       <= SEL_RF;
      rs2_sel       <= SEL_RF;
    end else if (action != ACT_FREEZE) begin
      mem_valid     <= ex_valid;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      if (advance) begin
        ex_valid     <= de_valid;
        ex_rd        <= de_rd;
        ex_reg_write <= de_reg_write;
        ex_mem_read  <= de_mem_read;
      end else begin
        ex_valid     <= 1'b0;
        ex_rd        <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
      end
      rs1_sel <= rs1_sel_next;
      rs2_sel <= rs2_sel_next;
    end
  end

  // Event counters stop at all-ones so a long debug run never reads back as a small count.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      busy_cnt  <= '0;
    end else begin
      if (action == ACT_STALL && stall_cnt != '1)  stall_cnt <= stall_cnt + CNT_W'(1);
      if (action == ACT_SQUASH && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      if (action == ACT_FREEZE && busy_cnt != '1)  busy_cnt  <= busy_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; counters narrowed to 4 bits so saturation is reachable.
module tb_hazard_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          de_valid;
  logic [4:0]    de_rs1;
  logic [4:0]    de_rs2;
  logic          de_rs1_used;
  logic          de_rs2_used;
  logic [4:0]    de_rd;
  logic          de_reg_write;
  logic          de_mem_read;
  logic          br_taken;
  logic          mem_busy;
  logic          pc_write;
  logic          de_ld;
  logic          de_flush;
  logic          ex_ld;
  logic          ex_flush;
  logic [1:0]    rs1_sel;
  logic [1:0]    rs2_sel;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic [CW-1:0] busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  hazard_controller #(.CNT_W(CW), .XLEN_IDX(5)) dut (
    .clk(clk), .reset(reset),
    .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .de_rd(de_rd), .de_reg_write(de_reg_write), .de_mem_read(de_mem_read),
    .br_taken(br_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .de_ld(de_ld), .de_flush(de_flush),
    .ex_ld(ex_ld), .ex_flush(ex_flush),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_de(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic mr);
    de_valid = v; de_rs1 = rs1; de_rs2 = rs2; de_rs1_used = u1; de_rs2_used = u2;
    de_rd = rd; de_reg_write = wr; de_mem_read = mr;
  endtask

  task automatic nop_de();
    set_de(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; br_taken = 1'b0; mem_busy = 1'b0;
    nop_de();
    tick();
    sample();
    check("rst_pc_write", pc_write, 0);
    check("rst_de_ld",    de_ld,    0);
    check("rst_ex_ld",    ex_ld,    0);
    check("rst_de_flush", de_flush, 1);
    check("rst_ex_flush", ex_flush, 1);
    check("rst_rs1_sel",  rs1_sel,  0);
    check("rst_stall",    stall_cnt, 0);
    tick();
    reset = 1'b0;

    // add x5,x1,x2 ; sub x6,x5,x3
    set_de(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    sample(); check("alu_pc1", pc_write, 1); check("alu_exfl1", ex_flush, 0);
    tick();
    set_de(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0);
    sample(); check("alu_pc2", pc_write, 1);
    tick();
    nop_de();
    sample();
    check("alu_rs1_sel", rs1_sel, 1);
    check("alu_rs2_sel", rs2_sel, 0);
    check("alu_pc3", pc_write, 1);
    tick();

    // add x5 ; nop ; or x7,x5,x5
    set_de(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); tick();
    nop_de(); tick();
    set_de(1, 5'd5, 5'd5, 1, 1, 5'd7, 1, 0); tick();
    nop_de();
    sample();
    check("d2_rs1_sel", rs1_sel, 2);
    check("d2_rs2_sel", rs2_sel, 2);
    tick();

    // lw x8 ; add x9,x8,x1
    set_de(1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1); tick();
    set_de(1, 5'd8, 5'd1, 1, 1, 5'd9, 1, 0);
    sample();
    check("lu_pc_write", pc_write, 0);
    check("lu_de_ld",    de_ld,    0);
    check("lu_ex_ld",    ex_ld,    1);
    check("lu_ex_flush", ex_flush, 1);
    tick();
    sample();
    check("lu_resume_pc", pc_write, 1);
    check("lu_resume_exfl", ex_flush, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    tick();
    nop_de();
    sample();
    check("lu_rs1_sel", rs1_sel, 2);
    check("lu_rs2_sel", rs2_sel, 0);
    tick();

    // lw x10 ; add x11,x10,x10 with a coincident taken branch
    set_de(1, 5'd0, 5'd0, 0, 0, 5'd10, 1, 1); tick();
    set_de(1, 5'd10, 5'd10, 1, 1, 5'd11, 1, 0);
    br_taken = 1'b1;
    sample();
    check("br_de_flush", de_flush, 1);
    check("br_ex_flush", ex_flush, 1);
    check("br_pc_write", pc_write, 1);
    check("br_de_ld",    de_ld,    1);
    tick();
    br_taken = 1'b0;
    nop_de();
    sample();
    check("br_flush_cnt", flush_cnt, 1);
    check("br_stall_cnt", stall_cnt, 1);
    check("br_rs1_sel",   rs1_sel,   0);
    tick();

    // lw x0 ; add x12,x0,x0
    set_de(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1); tick();
    set_de(1, 5'd0, 5'd0, 1, 1, 5'd12, 1, 0);
    sample();
    check("x0_pc_write", pc_write, 1);
    check("x0_ex_flush", ex_flush, 0);
    tick();
    nop_de();
    sample();
    check("x0_rs1_sel", rs1_sel, 0);
    check("x0_rs2_sel", rs2_sel, 0);
    check("x0_stall_cnt", stall_cnt, 1);
    tick();

    // add x13 ; sub x14,x13,x3 then freeze three cycles with the forward pending
    set_de(1, 5'd1, 5'd2, 1, 1, 5'd13, 1, 0); tick();
    set_de(1, 5'd13, 5'd3, 1, 1, 5'd14, 1, 0); tick();
    nop_de();
    mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("fz_pc_write", pc_write, 0);
      check("fz_de_ld",    de_ld,    0);
      check("fz_ex_ld",    ex_ld,    0);
      check("fz_flushes",  {de_flush, ex_flush}, 0);
      check("fz_rs1_sel",  rs1_sel,  1);
      check("fz_busy_cnt", busy_cnt, k);
      tick();
    end
    mem_busy = 1'b0;
    sample();
    check("fz_busy_cnt3", busy_cnt, 3);
    check("fz_resume_sel", rs1_sel, 1);
    check("fz_resume_pc", pc_write, 1);
    tick();
    sample();
    check("fz_after_sel", rs1_sel, 0);
    tick();

    // flush_cnt is 1; 14 more branches reach all-ones, then it must hold
    br_taken = 1'b1;
    for (int k = 0; k < 14; k++) tick();
    sample(); check("sat_reach", flush_cnt, 15);
    for (int k = 0; k < 3; k++) tick();
    sample(); check("sat_hold", flush_cnt, 15);
    br_taken = 1'b0;

    // set up a forward, freeze, then reset mid-freeze
    set_de(1, 5'd1, 5'd2, 1, 1, 5'd15, 1, 0); tick();
    set_de(1, 5'd15, 5'd3, 1, 1, 5'd16, 1, 0); tick();
    nop_de();
    mem_busy = 1'b1;
    sample(); check("rf_sel_before", rs1_sel, 1);
    tick();
    sample(); check("rf_busy_cnt", busy_cnt, 4);
    reset = 1'b1;
    sample();
    check("rf_de_flush", de_flush, 1);
    check("rf_ex_flush", ex_flush, 1);
    check("rf_pc_write", pc_write, 0);
    check("rf_ex_ld",    ex_ld,    0);
    tick();
    reset = 1'b0;
    mem_busy = 1'b0;
    sample();
    check("rf_flush_cnt", flush_cnt, 0);
    check("rf_busy_cnt0", busy_cnt,  0);
    check("rf_stall_cnt", stall_cnt, 0);
    check("rf_rs1_sel",   rs1_sel,   0);
    check("rf_rs2_sel",   rs2_sel,   0);
    check("rf_normal_pc", pc_write,  1);
    check("rf_normal_fl", de_flush,  0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central pipeline sequencer for the 5-stage core (IF, DE, EX, MEM, WB).
- Tracks destination registers in flight, then drives the existing pipeline-register controls:
  - pc_write on the IF register;
  - load/flush on the DE and EX registers;
  - EX operand-forwarding selects.
- Resolves, in a fixed priority, load-use hazards, taken-branch squashes and memory-busy freezes.
- Replaces the standalone forwarding unit; exposes saturating event counters for debug.

Parameters:
- CNT_W, 16, width of each saturating event counter.
- XLEN_IDX, 5, register index width.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- de_valid  in  1  DE stage holds a real instruction.
- de_rs1  in  XLEN_IDX  rs1 index of the instruction in DE.
- de_rs2  in  XLEN_IDX  rs2 index of the instruction in DE.
- de_rs1_used  in  1  instruction in DE reads rs1.
- de_rs2_used  in  1  instruction in DE reads rs2.
- de_rd  in  XLEN_IDX  rd index of the instruction in DE.
- de_reg_write  in  1  instruction in DE writes rd.
- de_mem_read  in  1  instruction in DE is a load.
- br_taken  in  1  EX resolved a taken branch/jump (br_res != 0) this cycle.
- mem_busy  in  1  data memory cannot complete this cycle.
- pc_write  out  1  IF register load enable.
- de_ld  out  1  DE register load enable.
- de_flush  out  1  DE register synchronous clear.
- ex_ld  out  1  EX register load enable.
- ex_flush  out  1  EX register synchronous clear (bubble).
- rs1_sel  out  2  EX rs1 source: 0 regfile, 1 MEM alu_result, 2 WB result.
- rs2_sel  out  2  same encoding as rs1_sel, for rs2.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  taken-branch squashes.
- busy_cnt  out  CNT_W  mem_busy freeze cycles.

Behaviour:
- Shadow scoreboard:
  - Two slots, EX and MEM; each holds {valid, rd, reg_write, mem_read}.
  - Each clock that is not a freeze: MEM <= EX; EX <= DE fields, or a bubble (valid=0) if the DE instruction does not advance.
- Match rule: a slot matches rs when valid & reg_write & rd == rs & rs != 0 & the corresponding used bit is set.
- Control outputs are combinational, evaluated in this priority:
  1. reset: pc_write=0, de_ld=0, ex_ld=0, de_flush=1, ex_flush=1.
  2. mem_busy (freeze): pc_write=0, de_ld=0, ex_ld=0, no flushes. Scoreboard and sel registers hold. busy_cnt++.
  3. br_taken (squash): pc_write=1, de_ld=1, de_flush=1, ex_ld=1, ex_flush=1. Scoreboard EX slot <= bubble. flush_cnt++. Any concurrent load-use is ignored.
  4. load-use, i.e. de_valid & EX slot valid & mem_read & matches rs1 or rs2: pc_write=0, de_ld=0, ex_ld=1, ex_flush=1. Scoreboard EX slot <= bubble. stall_cnt++.
  5. normal: pc_write=1, de_ld=1, ex_ld=1, no flushes.
- Forwarding selects:
  - Registered, valid during the cycle the instruction is in EX.
  - At a non-freeze edge, for each rs: EX-slot match -> 1; else MEM-slot match -> 2; else 0. EX-slot has priority over MEM-slot (youngest wins).
  - If DE does not advance, or is flushed, the sels load 0.
  - Freeze holds the sels.
- Regfile write-before-read is required. Retiring-WB matches are not forwarded.
- Counters:
  - Increment at most once per cycle.
  - Saturate at all-ones (no wrap); reset to 0.
- Reset, every cycle while asserted: scoreboard all invalid, rs1_sel=rs2_sel=0, counters=0, control outputs as in priority 1.
  - Reset asserted mid-stall or mid-freeze overrides it at once.
  - The first post-reset cycle is normal.
- Latency: decisions are same-cycle combinational. A load-use costs exactly 1 bubble; a taken branch costs 2 squashed slots.

Test Plan:
- Back-to-back ALU, "add x5,x1,x2" then "sub x6,x5,x3" -> second instruction in EX has rs1_sel=1, rs2_sel=0; pc_write=1 throughout.
- Distance-2 RAW (add x5, nop, or x7,x5,x5) -> rs1_sel=rs2_sel=2 in EX.
- "lw x8" then "add x9,x8,x1" -> exactly 1 cycle of pc_write=0, de_ld=0, ex_flush=1; next cycle rs1_sel=2; stall_cnt=1.
- br_taken coincident with a load-use condition -> de_flush=ex_flush=1, pc_write=1, no stall; flush_cnt=1, stall_cnt=0.
- Write to x0 followed by a read of x0 -> sels stay 0, no stall even when the producer is a load.
- mem_busy held 3 cycles during a pending forward -> all ld=0 and sels held for 3 cycles, busy_cnt=3; then resume with correct sel.
- Preload flush_cnt near all-ones via repeated branches -> holds at all-ones; reset asserted mid-freeze -> next cycle counters 0, sels 0.
